// File: rtl/px_out_fifo_pkg.sv
// rtl/px_out_fifo_pkg.sv - shared parameters for the pixel output FIFO
//
// Purpose: default pixel width, FIFO depth and occupancy-counter width used by
//          px_out_fifo, px_fifo_mem and anything that talks to them.
// Ports:   none (package).
package px_out_fifo_pkg;

  localparam int MAX_PIXEL_BITS = 8;
  localparam int PX_FIFO_DEPTH  = 4;
  localparam int DROP_CNT_BITS  = 8;

  // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 states.
  function automatic int px_lvl_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PX_FIFO_LVL_BITS = px_lvl_bits(PX_FIFO_DEPTH);

endpackage

// File: rtl/px_fifo_mem.sv
// rtl/px_fifo_mem.sv - DEPTH x WIDTH register array, one write port, one async read port
//
// Purpose: pixel storage for px_out_fifo. No reset: contents are only
//          meaningful where the owning FIFO's pointers say so.
// Ports:   clk_i  - clock
//          we     - write enable
//          waddr  - write address
//          wdata  - write data
//          raddr  - read address (combinational read)
//          rdata  - read data
module px_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/px_out_fifo.sv
// rtl/px_out_fifo.sv - first-word fall-through pixel FIFO between Sobel output and SPI
//
// Purpose: buffers single-cycle pixel strobes from top_gray_sobel and presents
//          the head pixel to spi_control until acknowledged. Overflowing
//          pushes are dropped and flagged with a sticky overflow bit.
// Build option: define PX_OUT_FIFO_STATS_EN to add drop_cnt_o, a saturating
//          8-bit count of dropped pixels cleared by clr_ovf_i.
// Ports:   clk_i       - clock
//          reset_i     - synchronous active-high reset
//          px_rdy_i    - push strobe
//          px_i        - pixel to push
//          px_rdy_o    - head pixel valid (FIFO non-empty)
//          px_o        - head pixel, 0 while empty
//          px_ack_i    - pop request, ignored while empty
//          level_o     - occupancy
//          full_o      - level_o == DEPTH
//          empty_o     - level_o == 0
//          overflow_o  - sticky drop flag
//          clr_ovf_i   - clears overflow_o (and drop_cnt_o)
//          drop_cnt_o  - dropped-pixel count (PX_OUT_FIFO_STATS_EN only)
module px_out_fifo
  import px_out_fifo_pkg::*;
#(
  parameter int WIDTH = MAX_PIXEL_BITS,
  parameter int DEPTH = PX_FIFO_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          px_rdy_i,
  input  logic [WIDTH-1:0]              px_i,
  output logic                          px_rdy_o,
  output logic [WIDTH-1:0]              px_o,
  input  logic                          px_ack_i,
  output logic [px_lvl_bits(DEPTH)-1:0] level_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          overflow_o,
  input  logic                          clr_ovf_i
`ifdef PX_OUT_FIFO_STATS_EN
  ,
  output logic [DROP_CNT_BITS-1:0]      drop_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = px_lvl_bits(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [WIDTH-1:0] head;

  logic is_empty;
  logic is_full;
  logic pop;
  logic wr_en;
  logic drop;

  assign is_empty = (level == '0);
  assign is_full  = (level == LW'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop. Ack on an empty FIFO is a no-op.
  assign pop   = px_ack_i & ~is_empty;
  assign wr_en = px_rdy_i & (~is_full | pop);
  assign drop  = px_rdy_i & is_full & ~pop;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(wr_en) - LW'(pop);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf_i) begin
        overflow <= 1'b0;
      end
    end
  end

  px_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i (clk_i),
    .we    (wr_en & ~reset_i),
    .waddr (wr_ptr),
    .wdata (px_i),
    .raddr (rd_ptr),
    .rdata (head)
  );

`ifdef PX_OUT_FIFO_STATS_EN
  logic [DROP_CNT_BITS-1:0] drop_cnt;

  // Increment wins over clear: a drop coinciding with a clear counts as 1.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (clr_ovf_i) begin
        drop_cnt <= DROP_CNT_BITS'(1);
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_CNT_BITS'(1);
      end
    end else if (clr_ovf_i) begin
      drop_cnt <= '0;
    end
  end

  assign drop_cnt_o = drop_cnt;
`endif

  // Storage is never cleared, so mask the stale head while empty.
  assign px_o       = is_empty ? '0 : head;
  assign px_rdy_o   = ~is_empty;
  assign level_o    = level;
  assign full_o     = is_full;
  assign empty_o    = is_empty;
  assign overflow_o = overflow;

endmodule
